hring_boundary_inject_arb: RTL and testbench
============================================

Name: hring_boundary_inject_arb

Overview:
- Sequences and shares one clock-boundary crossing between a ring pass-through slot and N local injection requesters.
- Each cycle, selects one flit and drives it registered into the boundary's port0_ci.
- Pass-through traffic has priority; local requesters share the remaining slots round-robin.
- A starvation FSM throttles the upstream ring to force a bubble when a local requester waits too long.

Parameters:
- W, 144, control word width (`control_w); bit W-1 is the valid bit.
- N, 4, number of local injection requesters (2..8).
- STARVE_LIMIT, 15, cycles a requester may wait before the ring is throttled.
- CW, 4, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- ring_in  in  W  pass-through flit from upstream ring; valid = ring_in[W-1].
- ring_stall  out  1  request to upstream to leave the next slot empty.
- req_valid  in  N  per-requester flit pending.
- req_flit  in  N*W  requester i flit at [i*W +: W].
- req_grant  out  N  one-hot; requester i's flit is consumed this cycle.
- port0_ci  out  W  registered flit into the clock boundary.
- starved  out  1  FSM is in the THROTTLE state (debug/stat).

Behaviour:
- Reset (rst=0, async): port0_ci=0, ring_stall=0, starved=0, rr_ptr=0, starve_cnt=0, FSM=ARB.
- req_grant is combinational; it is forced to 0 while rst=0.
- Arbitration, each cycle:
  - ring_in[W-1]=1: next port0_ci=ring_in; req_grant=0.
  - ring_in[W-1]=0 and any req_valid: grant the first set bit searching from rr_ptr upward with wrap mod N. Next port0_ci=that req_flit with bit W-1 forced to 1. Next rr_ptr=(granted index+1) mod N.
  - Neither: next port0_ci=0.
- Latency: exactly 1 cycle from selection to port0_ci. The requester must drop or advance its flit the cycle after grant. A requester's flit is never duplicated or dropped.
- rr_ptr changes only on a grant.
- Starvation counter:
  - Increments when any req_valid=1 and no grant is issued; saturates at STARVE_LIMIT.
  - Clears to 0 on any grant, or when req_valid=0.
- FSM:
  - ARB → THROTTLE when starve_cnt reaches STARVE_LIMIT.
  - THROTTLE: ring_stall=1 (registered; asserts the cycle after entry) and starved=1.
  - THROTTLE → ARB on the cycle a local grant occurs; ring_stall deasserts the next cycle.
  - THROTTLE → ARB also if req_valid becomes 0.
  - Upstream honours ring_stall within 1 cycle. The arbiter does not assume it, and still gives a valid ring_in priority.
- Simultaneous events:
  - Valid ring_in and a starved requester in the same cycle: ring wins, and the counter stays saturated.
  - A grant in the same cycle as reaching the limit: no THROTTLE entry.
- Reset mid-operation: all state clears immediately, and any in-flight registered flit is lost. Requesters must re-present their flits after reset.
- N=1: rr_ptr is held at 0.

Test Plan:
- Reset then idle: rst=0→1, all inputs 0 → port0_ci=0, req_grant=0, ring_stall=0 across 5 clocks.
- Pass-through priority: ring_in=144'h8000…0123456789abcdef0123456789abcdef, req_valid=4'b0001 → req_grant=0, port0_ci equals ring_in after 1 clock.
- Round-robin: ring_in invalid, req_valid=4'b1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3. Each port0_ci has bit 143=1 and the matching payload.
- Sparse wrap: rr_ptr=3, req_valid=4'b0101 → grant requester 0, then requester 2, then requester 0.
- Starvation: ring_in valid every cycle, req_valid=4'b0010 → starved=1 after 15 blocked cycles, ring_stall=1 one cycle later. Drop ring_in valid → grant requester 1, ring_stall=0 the following cycle, starve_cnt=0.
- Async reset mid-throttle: assert rst=0 between clock edges while ring_stall=1 → ring_stall, starved and port0_ci go to 0 immediately without a clock edge.

Source files
------------

// File: rtl/hring_boundary_inject_arb.sv
// Shares one clock-boundary crossing between a ring pass-through slot and N local
// injection requesters; ring traffic has priority, locals share leftovers round-robin.
module hring_boundary_inject_arb #(
  parameter int W            = 144,
  parameter int N            = 4,
  parameter int STARVE_LIMIT = 15,
  parameter int CW           = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   ring_in,
  output logic           ring_stall,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_flit,
  output logic [N-1:0]   req_grant,
  output logic [W-1:0]   port0_ci,
  output logic           starved
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic {
    ARB      = 1'b0,
    THROTTLE = 1'b1
  } state_t;

  // Handshake: req_grant[i] is the ready for requester i's valid/flit pair; the
  // flit is consumed in any cycle where req_valid[i] and req_grant[i] are both 1.

  state_t        state, state_next;
  logic [PW-1:0] rr_ptr, rr_next;
  logic [CW-1:0] starve_cnt, cnt_next;
  logic [PW-1:0] grant_idx, cand;
  logic          found;
  logic          grant_ok;
  logic [W-1:0]  sel_flit;

  // First pending requester at or after rr_ptr, wrapping mod N.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign grant_ok = rst && found && !ring_in[W-1];
  assign rr_next  = (N > 1) ? PW'((int'(grant_idx) + 1) % N) : '0;

  always_comb begin
    req_grant = '0;
    sel_flit  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == PW'(i)) begin
        req_grant[i] = grant_ok;
        sel_flit     = req_flit[i*W +: W];
      end
    end
  end

  always_comb begin
    cnt_next = starve_cnt;
    if (req_valid == '0 || grant_ok)
      cnt_next = '0;
    else if (starve_cnt >= LIMIT)
      cnt_next = LIMIT;
    else
      cnt_next = starve_cnt + CW'(1);
  end

  // A grant clears cnt_next, so a grant on the limit cycle never enters THROTTLE.
  always_comb begin
    state_next = state;
    case (state)
      ARB:      if (cnt_next == LIMIT) state_next = THROTTLE;
      THROTTLE: if (grant_ok || req_valid == '0) state_next = ARB;
      default:  state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      port0_ci   <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
      state      <= ARB;
      ring_stall <= 1'b0;
      starved    <= 1'b0;
    end else begin
      if (ring_in[W-1])
        port0_ci <= ring_in;
      else if (grant_ok)
        port0_ci <= {1'b1, sel_flit[W-2:0]};
      else
        port0_ci <= '0;
      if (grant_ok)
        rr_ptr <= rr_next;
      starve_cnt <= cnt_next;
      state      <= state_next;
      starved    <= (state_next == THROTTLE);
      // Stall lags THROTTLE entry by one cycle but drops together with the exit.
      ring_stall <= (state == THROTTLE) && (state_next == THROTTLE);
    end
  end

endmodule

// File: tb/tb_hring_boundary_inject_arb.sv
// Directed bench for hring_boundary_inject_arb: literal checks plus a per-cycle
// comparison against a behavioural model of the arbitration and starvation rules.
module tb_hring_boundary_inject_arb;

  localparam int W     = 144;
  localparam int N     = 4;
  localparam int LIMIT = 15;

  logic           clk;
  logic           rst;
  logic [W-1:0]   ring_in;
  logic           ring_stall;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_flit;
  logic [N-1:0]   req_grant;
  logic [W-1:0]   port0_ci;
  logic           starved;

  hring_boundary_inject_arb #(.W(W), .N(N), .STARVE_LIMIT(LIMIT), .CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ring_in    (ring_in),
    .ring_stall (ring_stall),
    .req_valid  (req_valid),
    .req_flit   (req_flit),
    .req_grant  (req_grant),
    .port0_ci   (port0_ci),
    .starved    (starved)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  bit chk_en = 1'b0;

  localparam logic [W-1:0] RING = {16'h8000, 128'h0123456789abcdef0123456789abcdef};
  // Requester i flit: {16'h0000, 64'hC0DE00000000000i, 64'h0123456789ABCDEF}
  localparam logic [W-1:0] F0V = {16'h8000, 64'hC0DE000000000000, 64'h0123456789ABCDEF};
  localparam logic [W-1:0] F1V = {16'h8000, 64'hC0DE000000000001, 64'h0123456789ABCDEF};
  localparam logic [W-1:0] F2V = {16'h8000, 64'hC0DE000000000002, 64'h0123456789ABCDEF};
  localparam logic [W-1:0] F3V = {16'h8000, 64'hC0DE000000000003, 64'h0123456789ABCDEF};

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_rr      = 0;
  int           m_wait    = 0;
  bit           m_thr     = 1'b0;
  bit           m_stall   = 1'b0;
  logic [W-1:0] m_port    = '0;

  function automatic int pick(input logic [W-1:0] rin, input logic [N-1:0] rv, input int rr);
    if (rin[W-1]) return -1;
    for (int k = 0; k < N; k++) begin
      if (rv[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    bit was_thr;
    logic [W-1:0] vbit;
    vbit = {1'b1, {(W-1){1'b0}}};
    if (!rst) begin
      m_rr = 0; m_wait = 0; m_thr = 1'b0; m_stall = 1'b0; m_port = '0;
    end else begin
      g = pick(ring_in, req_valid, m_rr);
      if (ring_in[W-1])  m_port = ring_in;
      else if (g >= 0)   m_port = req_flit[g*W +: W] | vbit;
      else               m_port = '0;
      if (g >= 0) m_rr = (g + 1) % N;
      if (req_valid == '0 || g >= 0) m_wait = 0;
      else if (m_wait < LIMIT)       m_wait = m_wait + 1;
      was_thr = m_thr;
      if (was_thr) m_thr = !(g >= 0 || req_valid == '0);
      else         m_thr = (m_wait == LIMIT);
      m_stall = was_thr && m_thr;
    end
  end

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] eg;
    if (rst && chk_en) begin
      g  = pick(ring_in, req_valid, m_rr);
      eg = (g >= 0) ? (N'(1) << g) : '0;
      check("model_grant", W'(req_grant), W'(eg));
      check("model_port0_ci", port0_ci, m_port);
      check("model_ring_stall", W'(ring_stall), W'(m_stall));
      check("model_starved", W'(starved), W'(m_thr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] rin, input logic [N-1:0] rv);
    ring_in   = rin;
    req_valid = rv;
    #1;
  endtask

  logic [N-1:0] rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [N-1:0] sp_exp [3] = '{4'b0001, 4'b0100, 4'b0001};

  initial begin
    rst       = 1'b0;
    ring_in   = '0;
    req_valid = '0;
    for (int i = 0; i < N; i++)
      req_flit[i*W +: W] = {16'h0000, 64'hC0DE000000000000 + 64'(i), 64'h0123456789ABCDEF};

    // Reset state
    #2;
    check("rst_port0_ci", port0_ci, '0);
    check("rst_grant", W'(req_grant), '0);
    check("rst_ring_stall", W'(ring_stall), '0);
    check("rst_starved", W'(starved), '0);
    tick();
    #2 rst = 1'b1;
    chk_en = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_port0_ci", port0_ci, '0);
      check("idle_ring_stall", W'(ring_stall), '0);
    end

    // Pass-through priority
    drive(RING, 4'b0001);
    check("pass_grant", W'(req_grant), '0);
    tick();
    check("pass_port0_ci", port0_ci, RING);

    // Round-robin over all four
    exp_q = '{F0V, F1V, F2V, F3V, F0V, F1V, F2V, F3V};
    drive('0, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      check("rr_grant", W'(req_grant), W'(rr_exp[k]));
      tick();
      check("rr_port0_ci", port0_ci, exp_q.pop_front());
    end

    // Sparse wrap: move rr_ptr to 3, then 0101 grants 0,2,0
    drive('0, 4'b0100);
    check("sp_setup_grant", W'(req_grant), W'(4'b0100));
    tick();
    exp_q = '{F0V, F2V, F0V};
    drive('0, 4'b0101);
    for (int k = 0; k < 3; k++) begin
      check("sp_grant", W'(req_grant), W'(sp_exp[k]));
      tick();
      check("sp_port0_ci", port0_ci, exp_q.pop_front());
    end

    // Starvation: ring valid blocks requester 1
    drive(RING, 4'b0010);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 14) check("stv_starved_14", W'(starved), '0);
      if (e == 15) begin
        check("stv_starved_15", W'(starved), W'(1'b1));
        check("stv_stall_15", W'(ring_stall), '0);
      end
      if (e == 16) begin
        check("stv_stall_16", W'(ring_stall), W'(1'b1));
        check("stv_port0_ci", port0_ci, RING);
      end
    end
    check("stv_grant_blocked", W'(req_grant), '0);
    drive('0, 4'b0010);
    check("stv_grant_release", W'(req_grant), W'(4'b0010));
    tick();
    check("stv_release_stall", W'(ring_stall), '0);
    check("stv_release_starved", W'(starved), '0);
    check("stv_release_port0_ci", port0_ci, F1V);

    // Counter must have cleared: needs a full 15 blocked cycles again
    drive(RING, 4'b0010);
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 14) check("re_starved_14", W'(starved), '0);
    end
    check("re_stall", W'(ring_stall), W'(1'b1));

    // Async reset mid-throttle, between edges
    #2 rst = 1'b0;
    #1;
    check("arst_ring_stall", W'(ring_stall), '0);
    check("arst_starved", W'(starved), '0);
    check("arst_port0_ci", port0_ci, '0);
    check("arst_grant", W'(req_grant), '0);
    drive('0, '0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    drive('0, 4'b1000);
    check("post_rst_grant", W'(req_grant), W'(4'b1000));
    tick();
    check("post_rst_port0_ci", port0_ci, F3V);
    drive('0, '0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
